wsc_solver: RTL and testbench
=============================

Name: wsc_solver

Overview:
- Sequential controller that plays the wolf/sheep/cabbage river-crossing puzzle against the `wsc` environment block.
- Observes the 4-bit puzzle state and issues one crossing command at a time.
- Treats the environment's state update as the acknowledgement of each command.
- Reports done, error with an error code, and the crossing count; replaces a combinational move generator with a synthesizable initiator.

Parameters:
ACK_TIMEOUT, 16, cycles to wait in WAIT_ACK for the state update before flagging TIMEOUT
MAX_STEPS, 15, crossings allowed before flagging LIMIT
STEP_W, 4, width of steps counter; must hold MAX_STEPS

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin a solve (sampled in IDLE, DONE, ERROR)
state  in  4  environment state: [3] farmer, [2] wolf, [1] sheep, [0] cab; 0 = start bank, 1 = far bank
move_valid  out  1  one-cycle command strobe
wolf  out  1  take wolf (valid with move_valid)
sheep  out  1  take sheep
cab  out  1  take cabbage
busy  out  1  solve in progress
done  out  1  puzzle solved (sticky)
error  out  1  solve failed (sticky)
err_code  out  3  0 EATEN, 1 STUCK, 2 TIMEOUT, 3 MISMATCH, 4 LIMIT
steps  out  STEP_W  crossings acknowledged this solve

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; all outputs 0; last_item=NONE.
- All outputs are registered.
- wolf/sheep/cab are at most one-hot and are 0 whenever move_valid=0.
- All-zero with move_valid=1 means the farmer crosses alone.
- Safety: a bank without the farmer must not hold wolf+sheep or sheep+cab.
- FSM states:
  - IDLE: start=1 -> clear steps, err_code, last_item; busy=1; -> CHECK.
  - CHECK, priority order:
    - state unsafe -> ERROR/EATEN.
    - state==4'b1111 -> DONE.
    - steps==MAX_STEPS -> ERROR/LIMIT.
    - otherwise select a move (rules below); none legal -> ERROR/STUCK; else latch item and expected next state -> ISSUE.
  - ISSUE: move_valid=1 for exactly one cycle with item bits; latch prev=state; clear timer; -> WAIT_ACK.
  - WAIT_ACK:
    - state==expected -> steps+1, last_item=item, -> CHECK.
    - state!=prev and !=expected -> ERROR/MISMATCH.
    - otherwise timer+1; timer==ACK_TIMEOUT -> ERROR/TIMEOUT.
    - When two events coincide, priority is ack > mismatch > timeout.
  - DONE: done=1, busy=0; start=1 -> behaves as IDLE start (done cleared).
  - ERROR: error=1, busy=0; err_code held; start=1 -> behaves as IDLE start (error and err_code cleared).
- Move selection (candidate must be on the farmer's bank and leave a safe bank behind):
  - farmer==0: first legal of wolf, sheep, cab, excluding last_item.
  - farmer==1: alone if legal; else first legal of wolf, sheep, cab, excluding last_item.
  - A candidate that is itself "alone" clears last_item on ack.
- Latency:
  - start sampled at edge k -> CHECK in cycle k+1 -> move_valid in cycle k+2.
  - After the ack edge: CHECK, then the next move_valid two cycles later.
- start while busy is ignored.
- rst during any state aborts immediately; no move_valid is emitted afterwards.
- steps saturates by construction because the LIMIT check stops further moves.

Decomposition:
- Package wsc_pkg:
  - state bit indices (FARMER=3, WOLF=2, SHEEP=1, CAB=0);
  - item_t enum {ITEM_NONE, ITEM_WOLF, ITEM_SHEEP, ITEM_CAB};
  - err_t enum (values above);
  - fsm_t enum;
  - function is_safe(logic [3:0]);
  - function apply_move(state, item) returning the expected state.
- Sub-module wsc_move_sel: combinational picker (inputs state, last_item; outputs item, legal). Shared with the environment's self-checking bench.

Test Plan:
- Reference solve: state=0000, env model applies each move 1 cycle after move_valid.
  -> items sheep, alone, wolf, sheep, cab, alone, sheep.
  -> done=1, steps=7, error=0.
  -> move_valid pulses spaced 3 cycles apart.
- Silent environment: state held at 0000.
  -> single move_valid (sheep=1), then ACK_TIMEOUT cycles later error=1, err_code=2, steps=0.
- Wrong response: first ack arrives as 1100 instead of 1010.
  -> error=1, err_code=3, steps=0.
- Unsafe start: start with state=0011.
  -> error=1, err_code=0 two cycles after start; no move_valid.
- MAX_STEPS=5 from 0000: env follows commands.
  -> error=1, err_code=4, steps=5 after the fifth ack.
  -> Then start with state=0000 -> error clears, solve restarts.
- Reset mid-operation: drop rst while in WAIT_ACK at step 3.
  -> busy, move_valid, steps=0 asynchronously.
  -> After rst release, no activity until start.

Source files
------------

// File: rtl/wsc_pkg.sv
// Shared types and helpers for the wolf/sheep/cabbage solver.
// Contents: state bit indices, item/error/FSM enums, and the is_safe /
// apply_move helpers. The environment's bench uses the same helpers.
package wsc_pkg;

  localparam int unsigned FARMER = 3;
  localparam int unsigned WOLF   = 2;
  localparam int unsigned SHEEP  = 1;
  localparam int unsigned CAB    = 0;

  typedef enum logic [1:0] {
    ITEM_NONE  = 2'd0,
    ITEM_WOLF  = 2'd1,
    ITEM_SHEEP = 2'd2,
    ITEM_CAB   = 2'd3
  } item_t;

  typedef enum logic [2:0] {
    ERR_EATEN    = 3'd0,
    ERR_STUCK    = 3'd1,
    ERR_TIMEOUT  = 3'd2,
    ERR_MISMATCH = 3'd3,
    ERR_LIMIT    = 3'd4
  } err_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT_ACK,
    S_DONE,
    S_ERROR
  } fsm_t;

  // A bank without the farmer must not hold wolf+sheep or sheep+cab.
  function automatic logic is_safe(input logic [3:0] s);
    logic w_alone, s_alone, c_alone;
    w_alone = (s[WOLF]  != s[FARMER]);
    s_alone = (s[SHEEP] != s[FARMER]);
    c_alone = (s[CAB]   != s[FARMER]);
    return !((w_alone && s_alone) || (s_alone && c_alone));
  endfunction

  // Farmer crosses; the chosen item (if any) ends up on the farmer's new bank.
  function automatic logic [3:0] apply_move(input logic [3:0] s, input item_t it);
    logic [3:0] ns;
    ns         = s;
    ns[FARMER] = ~s[FARMER];
    case (it)
      ITEM_WOLF:  ns[WOLF]  = ~s[FARMER];
      ITEM_SHEEP: ns[SHEEP] = ~s[FARMER];
      ITEM_CAB:   ns[CAB]   = ~s[FARMER];
      default:    ;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/wsc_solver_if.sv
// Command/observation bus between the solver (master) and the wsc
// environment (slave).
//   state      : environment state [3] farmer [2] wolf [1] sheep [0] cab
//   move_valid : one-cycle command strobe
//   wolf/sheep/cab : item taken with the farmer; all zero = farmer alone
interface wsc_solver_if;
  logic [3:0] state;
  logic       move_valid;
  logic       wolf;
  logic       sheep;
  logic       cab;

  modport master (input state, output move_valid, output wolf, output sheep, output cab);
  modport slave  (output state, input move_valid, input wolf, input sheep, input cab);
endinterface

// File: rtl/wsc_move_sel.sv
// Combinational move picker.
//   state     : current puzzle state
//   last_item : item moved by the previous crossing (never moved straight back)
//   item      : selected item, ITEM_NONE = farmer crosses alone
//   legal     : a legal move was found
// Farmer on the far bank prefers crossing alone; otherwise the first legal
// of wolf, sheep, cab that is on the farmer's bank and leaves a safe state.
module wsc_move_sel
  import wsc_pkg::*;
(
  input  logic [3:0] state,
  input  item_t      last_item,
  output item_t      item,
  output logic       legal
);

  function automatic logic cand_ok(input logic [3:0] s, input item_t last,
                                   input item_t cand, input logic on_bank);
    return (cand != last) && (on_bank == s[FARMER]) && is_safe(apply_move(s, cand));
  endfunction

  always_comb begin
    item  = ITEM_NONE;
    legal = 1'b0;
    if (state[FARMER] && is_safe(apply_move(state, ITEM_NONE))) begin
      legal = 1'b1;
    end else if (cand_ok(state, last_item, ITEM_WOLF, state[WOLF])) begin
      item  = ITEM_WOLF;
      legal = 1'b1;
    end else if (cand_ok(state, last_item, ITEM_SHEEP, state[SHEEP])) begin
      item  = ITEM_SHEEP;
      legal = 1'b1;
    end else if (cand_ok(state, last_item, ITEM_CAB, state[CAB])) begin
      item  = ITEM_CAB;
      legal = 1'b1;
    end
  end

endmodule

// File: rtl/wsc_solver.sv
// Sequential initiator that solves the wolf/sheep/cabbage puzzle against
// the wsc environment, one crossing command at a time. The environment's
// state update acknowledges each command.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : begin a solve (accepted in IDLE, DONE, ERROR)
//   bus      : command/state bus (master side)
//   busy     : solve in progress
//   done     : puzzle solved (sticky until next start)
//   error    : solve failed (sticky until next start)
//   err_code : failure reason (err_t encoding)
//   steps    : crossings acknowledged in this solve
module wsc_solver
  import wsc_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned MAX_STEPS   = 15,
  parameter int unsigned STEP_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  wsc_solver_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code,
  output logic [STEP_W-1:0] steps
);

  localparam int unsigned       TMR_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

  fsm_t             fsm;
  item_t            item_q;
  item_t            last_item;
  logic [3:0]       exp_state;
  logic [3:0]       prev_state;
  logic [TMR_W-1:0] timer;

  item_t            sel_item;
  logic             sel_legal;

  wsc_move_sel u_move_sel (
    .state     (bus.state),
    .last_item (last_item),
    .item      (sel_item),
    .legal     (sel_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm            <= S_IDLE;
      item_q         <= ITEM_NONE;
      last_item      <= ITEM_NONE;
      exp_state      <= '0;
      prev_state     <= '0;
      timer          <= '0;
      bus.move_valid <= 1'b0;
      bus.wolf       <= 1'b0;
      bus.sheep      <= 1'b0;
      bus.cab        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= '0;
      steps          <= '0;
    end else begin
      // Command strobe and item bits are only ever high for the ISSUE cycle.
      bus.move_valid <= 1'b0;
      bus.wolf       <= 1'b0;
      bus.sheep      <= 1'b0;
      bus.cab        <= 1'b0;

      case (fsm)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            steps     <= '0;
            err_code  <= '0;
            last_item <= ITEM_NONE;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            fsm       <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (!is_safe(bus.state)) begin
            err_code <= ERR_EATEN;
            error    <= 1'b1;
            busy     <= 1'b0;
            fsm      <= S_ERROR;
          end else if (bus.state == 4'b1111) begin
            done <= 1'b1;
            busy <= 1'b0;
            fsm  <= S_DONE;
          end else if (steps == STEP_MAX) begin
            err_code <= ERR_LIMIT;
            error    <= 1'b1;
            busy     <= 1'b0;
            fsm      <= S_ERROR;
          end else if (!sel_legal) begin
            err_code <= ERR_STUCK;
            error    <= 1'b1;
            busy     <= 1'b0;
            fsm      <= S_ERROR;
          end else begin
            item_q         <= sel_item;
            exp_state      <= apply_move(bus.state, sel_item);
            bus.move_valid <= 1'b1;
            bus.wolf       <= (sel_item == ITEM_WOLF);
            bus.sheep      <= (sel_item == ITEM_SHEEP);
            bus.cab        <= (sel_item == ITEM_CAB);
            fsm            <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          prev_state <= bus.state;
          timer      <= '0;
          fsm        <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          // Priority: ack > mismatch > timeout.
          if (bus.state == exp_state) begin
            steps     <= steps + 1'b1;
            last_item <= item_q;
            fsm       <= S_CHECK;
          end else if (bus.state != prev_state) begin
            err_code <= ERR_MISMATCH;
            error    <= 1'b1;
            busy     <= 1'b0;
            fsm      <= S_ERROR;
          end else if (timer == TMR_LAST) begin
            err_code <= ERR_TIMEOUT;
            error    <= 1'b1;
            busy     <= 1'b0;
            fsm      <= S_ERROR;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wsc_solver.sv
// Self-checking bench for wsc_solver: table-driven solve scenarios with an
// environment model and a move scoreboard, plus reset and step-limit sequences.
module tb_wsc_solver;
  import wsc_pkg::*;

  typedef enum int {ENV_FOLLOW, ENV_SILENT, ENV_WRONG} env_t;

  typedef struct {
    string           name;
    logic [3:0]      init;
    env_t            mode;
    int              n_moves;
    logic [7:0][2:0] moves;    // {wolf,sheep,cab} per crossing, index 0 first
    logic            exp_done;
    logic            exp_err;
    logic [2:0]      exp_code;
    logic [3:0]      exp_steps;
    int              exp_lat;  // cycles from start cycle to first flag cycle
  } case_t;

  localparam logic [2:0] M_W = 3'b100;
  localparam logic [2:0] M_S = 3'b010;
  localparam logic [2:0] M_C = 3'b001;
  localparam logic [2:0] M_A = 3'b000;
  localparam int N_CASES = 7;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, error_a, busy_b, done_b, error_b;
  logic [2:0] err_a, err_b;
  logic [3:0] steps_a, steps_b;

  wsc_solver_if ifa ();
  wsc_solver_if ifb ();

  wsc_solver #(.ACK_TIMEOUT(16), .MAX_STEPS(15), .STEP_W(4)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .error(error_a), .err_code(err_a), .steps(steps_a)
  );

  wsc_solver #(.ACK_TIMEOUT(16), .MAX_STEPS(5), .STEP_W(4)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .error(error_b), .err_code(err_b), .steps(steps_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [3:0] env_next(input logic [3:0] s, input logic [2:0] it);
    logic [3:0] n;
    n = s ^ 4'b1000;
    if (it[2]) n[2] = ~s[2];
    if (it[1]) n[1] = ~s[1];
    if (it[0]) n[0] = ~s[0];
    return n;
  endfunction

  // Environment models: respond one cycle after the command strobe.
  env_t       mode_a = ENV_FOLLOW;
  logic [3:0] nxt_a, nxt_b;

  initial begin
    ifa.state = 4'b0000;
    forever begin
      @(negedge clk);
      if (rst_a && ifa.move_valid) begin
        nxt_a = env_next(ifa.state, {ifa.wolf, ifa.sheep, ifa.cab});
        @(posedge clk);
        #1;
        if (mode_a == ENV_FOLLOW) ifa.state = nxt_a;
        else if (mode_a == ENV_WRONG) ifa.state = 4'b1100;
      end
    end
  end

  initial begin
    ifb.state = 4'b0000;
    forever begin
      @(negedge clk);
      if (rst_b && ifb.move_valid) begin
        nxt_b = env_next(ifb.state, {ifb.wolf, ifb.sheep, ifb.cab});
        @(posedge clk);
        #1;
        ifb.state = nxt_b;
      end
    end
  end

  // Scoreboards: expected items queued at start, popped on each strobe.
  logic [2:0] qa[$];
  logic [2:0] qb[$];
  int mv_count_a = 0;
  int prev_mv_a  = -1;

  initial begin
    logic [2:0] it, ex;
    forever begin
      @(negedge clk);
      if (ifa.move_valid) begin
        mv_count_a++;
        it = {ifa.wolf, ifa.sheep, ifa.cab};
        check("a_item_onehot", 32'($countones(it) <= 1), 1);
        if (qa.size() == 0) begin
          total++;
          $display("FAIL a_unexpected_move: got item %b, expected no move", it);
        end else begin
          ex = qa.pop_front();
          check("a_move_item", 32'(it), 32'(ex));
        end
        if (mode_a == ENV_FOLLOW && prev_mv_a >= 0)
          check("a_move_spacing", 32'(cyc - prev_mv_a), 3);
        prev_mv_a = cyc;
      end
    end
  end

  initial begin
    logic [2:0] it, ex;
    forever begin
      @(negedge clk);
      if (ifb.move_valid) begin
        it = {ifb.wolf, ifb.sheep, ifb.cab};
        if (qb.size() == 0) begin
          total++;
          $display("FAIL b_unexpected_move: got item %b, expected no move", it);
        end else begin
          ex = qb.pop_front();
          check("b_move_item", 32'(it), 32'(ex));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  case_t tbl[N_CASES];

  task automatic run_case(input int idx);
    case_t c;
    int t0, waited, mv0;
    c = tbl[idx];
    mode_a = c.mode;
    ifa.state = c.init;
    qa.delete();
    for (int i = 0; i < c.n_moves; i++) qa.push_back(c.moves[i]);
    prev_mv_a = -1;
    mv0 = mv_count_a;
    @(posedge clk);
    #1 start_a = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start_a = 1'b0;
    @(negedge clk);
    check({c.name, "_busy_after_start"}, 32'(busy_a), 1);
    check({c.name, "_flags_cleared"}, 32'(done_a | error_a), 0);
    waited = 0;
    while (!(done_a || error_a) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) check({c.name, "_flag_within_budget"}, 0, 1);
    check({c.name, "_latency"}, 32'(cyc - t0), 32'(c.exp_lat));
    check({c.name, "_done"}, 32'(done_a), 32'(c.exp_done));
    check({c.name, "_error"}, 32'(error_a), 32'(c.exp_err));
    check({c.name, "_steps"}, 32'(steps_a), 32'(c.exp_steps));
    check({c.name, "_busy_end"}, 32'(busy_a), 0);
    if (c.exp_err) check({c.name, "_err_code"}, 32'(err_a), 32'(c.exp_code));
    repeat (3) @(negedge clk);
    check({c.name, "_sticky"}, 32'({done_a, error_a}), 32'({c.exp_done, c.exp_err}));
    check({c.name, "_move_count"}, 32'(mv_count_a - mv0), 32'(c.n_moves));
    check({c.name, "_queue_empty"}, 32'(qa.size()), 0);
  endtask

  task automatic reset_test();
    int waited, mv0;
    logic found;
    mode_a = ENV_FOLLOW;
    ifa.state = 4'b0000;
    qa.delete();
    qa.push_back(M_S); qa.push_back(M_A); qa.push_back(M_W); qa.push_back(M_S);
    prev_mv_a = -1;
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    found = 1'b0;
    waited = 0;
    while (!found && waited < 100) begin
      @(negedge clk);
      waited++;
      if (ifa.move_valid && steps_a == 4'd3) found = 1'b1;
    end
    check("rst_reached_step3", 32'(found), 1);
    @(posedge clk);
    #2 rst_a = 1'b0;
    #1;
    check("rst_async_busy", 32'(busy_a), 0);
    check("rst_async_move_valid", 32'(ifa.move_valid), 0);
    check("rst_async_steps", 32'(steps_a), 0);
    qa.delete();
    mv0 = mv_count_a;
    @(negedge clk);
    #2 rst_a = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_quiet_moves", 32'(mv_count_a - mv0), 0);
    check("rst_quiet_flags", 32'({busy_a, done_a, error_a}), 0);
  endtask

  task automatic limit_run(input string tag);
    int waited;
    qb.delete();
    qb.push_back(M_S); qb.push_back(M_A); qb.push_back(M_W); qb.push_back(M_S); qb.push_back(M_C);
    ifb.state = 4'b0000;
    @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy_b), 1);
    check({tag, "_error_cleared"}, 32'(error_b), 0);
    check({tag, "_steps_cleared"}, 32'(steps_b), 0);
    waited = 0;
    while (!(done_b || error_b) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check({tag, "_flag_within_budget"}, 0, 1);
    check({tag, "_error"}, 32'(error_b), 1);
    check({tag, "_err_code"}, 32'(err_b), 4);
    check({tag, "_steps"}, 32'(steps_b), 5);
    check({tag, "_done"}, 32'(done_b), 0);
    check({tag, "_queue_empty"}, 32'(qb.size()), 0);
  endtask

  initial begin
    tbl[0] = '{"solve_0000", 4'b0000, ENV_FOLLOW, 7,
               {M_A, M_S, M_A, M_C, M_S, M_W, M_A, M_S}, 1'b1, 1'b0, 3'd0, 4'd7, 23};
    tbl[1] = '{"silent", 4'b0000, ENV_SILENT, 1,
               {M_A, M_A, M_A, M_A, M_A, M_A, M_A, M_S}, 1'b0, 1'b1, 3'd2, 4'd0, 19};
    tbl[2] = '{"wrong_ack", 4'b0000, ENV_WRONG, 1,
               {M_A, M_A, M_A, M_A, M_A, M_A, M_A, M_S}, 1'b0, 1'b1, 3'd3, 4'd0, 4};
    tbl[3] = '{"unsafe_0011", 4'b0011, ENV_FOLLOW, 0,
               {M_A, M_A, M_A, M_A, M_A, M_A, M_A, M_A}, 1'b0, 1'b1, 3'd0, 4'd0, 2};
    tbl[4] = '{"solve_1010", 4'b1010, ENV_FOLLOW, 6,
               {M_A, M_A, M_S, M_A, M_C, M_S, M_W, M_A}, 1'b1, 1'b0, 3'd0, 4'd6, 20};
    tbl[5] = '{"solved_1111", 4'b1111, ENV_FOLLOW, 0,
               {M_A, M_A, M_A, M_A, M_A, M_A, M_A, M_A}, 1'b1, 1'b0, 3'd0, 4'd0, 2};
    tbl[6] = '{"unsafe_1001", 4'b1001, ENV_FOLLOW, 0,
               {M_A, M_A, M_A, M_A, M_A, M_A, M_A, M_A}, 1'b0, 1'b1, 3'd0, 4'd0, 2};

    #12;
    check("reset_outputs_a",
          32'({busy_a, done_a, error_a, err_a, steps_a,
               ifa.move_valid, ifa.wolf, ifa.sheep, ifa.cab}), 0);
    check("reset_outputs_b", 32'({busy_b, done_b, error_b, err_b, steps_b, ifb.move_valid}), 0);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_without_start", 32'({busy_a, done_a, error_a}), 0);

    for (int i = 0; i < N_CASES; i++) run_case(i);
    reset_test();
    limit_run("limit_first");
    limit_run("limit_restart");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
